// File: rtl/timer_pkg.sv
// Shared types and constants for the compare/overflow timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CKS_DIV2  = 2'b00;
    localparam logic [1:0] CKS_DIV4  = 2'b01;
    localparam logic [1:0] CKS_DIV8  = 2'b10;
    localparam logic [1:0] CKS_DIV16 = 2'b11;

    localparam int unsigned FLAG_CMF = 0;
    localparam int unsigned FLAG_OVF = 1;
    localparam int unsigned FLAG_UDF = 2;

    // Prescaler bits that must all be ones for a tick at the selected division.
    function automatic logic [3:0] cks_mask(input logic [1:0] cks);
        case (cks)
            CKS_DIV2:  return 4'b0001;
            CKS_DIV4:  return 4'b0011;
            CKS_DIV8:  return 4'b0111;
            CKS_DIV16: return 4'b1111;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/timer_cmp_ctrl_if.sv
// Control/status bundle between the timer and its register block.
interface timer_cmp_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             i_en;
    logic [1:0]       i_cks;
    logic             i_dir;
    logic             i_oneshot;
    logic [CNT_W-1:0] i_tcor;
    logic             i_tcnt_wren;
    logic [CNT_W-1:0] i_tcnt_wdata;
    logic [2:0]       i_flag_clr;
    logic             i_cmie;
    logic             i_ovie;
    logic [CNT_W-1:0] o_tcnt;
    logic             o_cmf;
    logic             o_ovf;
    logic             o_udf;
    logic             o_irq;
    logic             o_busy;

    modport master (
        output i_en, i_cks, i_dir, i_oneshot, i_tcor, i_tcnt_wren, i_tcnt_wdata,
               i_flag_clr, i_cmie, i_ovie,
        input  o_tcnt, o_cmf, o_ovf, o_udf, o_irq, o_busy
    );

    modport slave (
        input  i_en, i_cks, i_dir, i_oneshot, i_tcor, i_tcnt_wren, i_tcnt_wdata,
               i_flag_clr, i_cmie, i_ovie,
        output o_tcnt, o_cmf, o_ovf, o_udf, o_irq, o_busy
    );
endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler with clock-select tick decode.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [PRE_W-1:0] cnt;
    logic [PRE_W-1:0] mask;

    always_comb begin
        mask = PRE_W'(cks_mask(cks));
        tick = run & ((cnt & mask) == mask);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/timer_cmp_ctrl.sv
// Up/down timer with compare, overflow/underflow flags and one-shot mode.
module timer_cmp_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PRE_W = 4
) (
    input  logic           i_clk_sys,
    input  logic           i_rst,
    timer_cmp_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] tcnt;
    logic             cmf;
    logic             ovf;
    logic             udf;
    logic             run;
    logic             tick;
    logic             pre_clr;
    logic             step;
    logic             up_cmp;
    logic             at_max;
    logic             dn_zero;
    logic             set_cmf;
    logic             set_ovf;
    logic             set_udf;

    timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk  (i_clk_sys),
        .rst  (i_rst),
        .run  (run),
        .clr  (pre_clr),
        .cks  (bus.i_cks),
        .tick (tick)
    );

    always_comb begin
        run     = (state == RUN);
        step    = tick & ~bus.i_tcnt_wren;
        up_cmp  = (tcnt == bus.i_tcor);
        at_max  = (tcnt == '1);
        dn_zero = (tcnt == '0);
        set_cmf = step & ~bus.i_dir & up_cmp;
        set_ovf = step & ~bus.i_dir & ~up_cmp & at_max;
        set_udf = step & bus.i_dir & dn_zero;
    end

    // Disable takes priority over a same-cycle one-shot terminal event.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.i_en) state_nx = RUN;
            RUN: begin
                if (!bus.i_en) state_nx = IDLE;
                else if ((set_cmf || set_udf) && bus.i_oneshot) state_nx = DONE;
            end
            DONE: if (!bus.i_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        pre_clr = bus.i_tcnt_wren
                | ((state == IDLE) && (state_nx == RUN))
                | ((state == DONE) && (state_nx == IDLE));
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            tcnt <= '0;
        end else if (bus.i_tcnt_wren) begin
            tcnt <= bus.i_tcnt_wdata;
        end else if (tick) begin
            if (bus.i_dir) begin
                tcnt <= dn_zero ? bus.i_tcor : tcnt - CNT_W'(1);
            end else if (up_cmp || at_max) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + CNT_W'(1);
            end
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            cmf <= 1'b0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            cmf <= set_cmf | (cmf & ~bus.i_flag_clr[FLAG_CMF]);
            ovf <= set_ovf | (ovf & ~bus.i_flag_clr[FLAG_OVF]);
            udf <= set_udf | (udf & ~bus.i_flag_clr[FLAG_UDF]);
        end
    end

    assign bus.o_tcnt = tcnt;
    assign bus.o_cmf  = cmf;
    assign bus.o_ovf  = ovf;
    assign bus.o_udf  = udf;
    assign bus.o_irq  = (cmf & bus.i_cmie) | ((ovf | udf) & bus.i_ovie);
    assign bus.o_busy = run;

endmodule

// File: doc/timer_cmp_ctrl.md
TIMER_CMP_CTRL -- requirements
Module: timer_cmp_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, counter and compare width.
REQ-002 Parameter PRE_W, default 4, prescaler counter width.
REQ-003 i_clk_sys  in  1  system clock; all logic on rising edge; single clock domain.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_en  in  1  timer enable from control register.
REQ-006 i_cks  in  2  clock select: 00 div2, 01 div4, 10 div8, 11 div16.
REQ-007 i_dir  in  1  0 = count up, 1 = count down.
REQ-008 i_oneshot  in  1  1 = stop after first terminal event.
REQ-009 i_tcor  in  CNT_W  compare/reload constant from the TCOR register.
REQ-010 i_tcnt_wren  in  1  software write strobe for the counter.
REQ-011 i_tcnt_wdata  in  CNT_W  software counter write data.
REQ-012 i_flag_clr  in  3  clear pulses: bit0 CMF, bit1 OVF, bit2 UDF.
REQ-013 i_cmie, i_ovie  in  1 each  compare and overflow/underflow interrupt enables.
REQ-014 o_tcnt  out  CNT_W  current counter value.
REQ-015 o_cmf, o_ovf, o_udf  out  1 each  sticky status flags.
REQ-016 o_irq  out  1  interrupt request.
REQ-017 o_busy  out  1  high while FSM is in RUN.

Function
REQ-018 FSM states IDLE, RUN, DONE. IDLE->RUN when i_en=1. RUN->IDLE when i_en=0. RUN->DONE on a terminal event when i_oneshot=1. DONE->IDLE when i_en=0.
REQ-019 Prescaler free-runs only in RUN and is cleared to 0 on every IDLE->RUN or DONE->IDLE transition.
REQ-020 Tick asserts for one cycle when the low (i_cks+1) prescaler bits are all ones: one tick per 2/4/8/16 RUN cycles. The first tick occurs 2/4/8/16 cycles after entering RUN.
REQ-021 An i_cks change in RUN takes effect on the next cycle without clearing the prescaler.
REQ-022 Up-mode tick, priority order:
 - o_tcnt==i_tcor: o_tcnt<=0, CMF set (terminal event).
 - else o_tcnt==all ones: o_tcnt<=0, OVF set.
 - else increment.
REQ-023 Down-mode tick:
 - o_tcnt==0: o_tcnt<=i_tcor, UDF set (terminal event).
 - else decrement.
REQ-024 Counter arithmetic is CNT_W-bit modulo; there is no carry output.
REQ-025 In IDLE and DONE, o_tcnt holds its value.
REQ-026 i_tcnt_wren loads i_tcnt_wdata in any state and overrides a same-cycle tick. No flag is set by the write. Prescaler is cleared in the same cycle.
REQ-027 Flags are sticky until the matching i_flag_clr bit is pulsed. Set wins over clear in the same cycle.
REQ-028 o_irq = (o_cmf & i_cmie) | ((o_ovf | o_udf) & i_ovie), combinational from registered flags: asserts the cycle after the event.
REQ-029 o_busy = (state==RUN).

Reset
REQ-030 On i_rst=1 at a clock edge:
 - state<=IDLE, prescaler<=0, o_tcnt<=0.
 - o_cmf, o_ovf, o_udf <= 0; hence o_irq=0, o_busy=0.
REQ-031 Reset mid-count abandons the count with no flag set. Reset has priority over i_tcnt_wren and flag logic.

Structure
REQ-032 Shared package timer_pkg holds the FSM state enum (IDLE/RUN/DONE), the clock-select encoding constants and the flag-clear bit indices.
REQ-033 Single sub-module timer_prescaler (prescaler counter plus tick decode). The FSM, counter and flags live in the top.

Verification
REQ-034 i_tcor=5, up, cks=00, en=1 -> o_tcnt steps 0..5 every 2 cycles; at the next tick o_tcnt=0 and CMF=1; with i_cmie=1, o_irq=1 the following cycle.
REQ-035 i_tcor=FF via write i_tcnt_wdata=FE, up, cks=01 -> o_tcnt=FF after 4 cycles, then 0 with CMF=1 and OVF=0 (compare wins at FF).
REQ-036 Down, i_tcor=3, o_tcnt=0, oneshot=1, cks=00 -> first tick gives o_tcnt=3, UDF=1, state DONE, o_busy=0; o_tcnt stays 3 until en=0.
REQ-037 i_flag_clr[0]=1 in the same cycle a compare sets CMF -> CMF=1; a clear pulse on a later cycle -> CMF=0, o_irq=0.
REQ-038 i_tcnt_wren with data 0x80 on a tick cycle -> o_tcnt=0x80, no increment, next tick a full period later.
REQ-039 i_rst=1 while in RUN at o_tcnt=0x42 with OVF=1 -> next cycle o_tcnt=0, all flags 0, o_busy=0; counting resumes only after the reset is released with en=1.
